// File: rtl/s_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s_arbiter_pkg
// Purpose  : Shared definitions for the per-slave arbitration stage. The
//            tracker state encoding is the same one used by the per-master
//            request trackers, so both sides agree on what m_stat means.
// Contents : trk_state_t - tracker states NO_REQ/WAIT/W_ACK/W_DATA
//            arb_state_t - arbiter FSM states IDLE/REQ
//            CMD_READ / CMD_WRITE - command bit values
// Revision : 1.0 - initial release
// ============================================================================
package s_arbiter_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } trk_state_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/s_arbiter_rq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : s_arbiter_rq_fifo
// Purpose  : In-order queue of master IDs whose reads were accepted by the
//            slave; the head tells the arbiter which master the next read
//            beat belongs to.
// Ports    : clk, reset (async, active-low)
//            push, push_id  - enqueue an ID (ignored when full)
//            pop            - dequeue the head (ignored when empty)
//            head           - ID at the head of the queue
//            full, empty    - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module s_arbiter_rq_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule
`default_nettype wire

// File: rtl/s_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : s_arbiter
// Purpose  : Per-slave arbitration stage. Picks one waiting master whose
//            target slave matches SLAVE_ID, forwards its request to the
//            slave, returns req_sent/ack_out/data_read strobes to the
//            trackers and routes in-order read data through an ID queue.
// Config   : S_ARB_RR_EN defined   -> round-robin arbitration
//            S_ARB_RR_EN undefined -> fixed priority, lowest index wins
// Ports    : clk, reset (async, active-low)
//            m_stat[2*N_M]  tracker states, master i at [2i+1:2i]
//            m_slave[N_M]   target slave bit per master
//            m_cmd[N_M]     command per master (1 write, 0 read)
//            req_sent/ack_out/data_read[N_M]  one-hot one-cycle strobes
//            s_req, s_cmd, s_mid  request to the slave
//            s_ack, s_rvalid      slave accept / read data valid
//            rq_full              response queue full
// Revision : 1.0 - initial release
// ============================================================================
module s_arbiter
  import s_arbiter_pkg::*;
#(
  parameter int N_M      = 2,
  parameter int SLAVE_ID = 0,
  parameter int RQ_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N_M-1:0]         m_stat,
  input  logic [N_M-1:0]           m_slave,
  input  logic [N_M-1:0]           m_cmd,
  output logic [N_M-1:0]           req_sent,
  output logic [N_M-1:0]           ack_out,
  output logic [N_M-1:0]           data_read,
  output logic                     s_req,
  output logic                     s_cmd,
  output logic [$clog2(N_M)-1:0]   s_mid,
  input  logic                     s_ack,
  input  logic                     s_rvalid,
  output logic                     rq_full
);

  localparam int MW = $clog2(N_M);

  arb_state_t     state, state_n;
  logic [N_M-1:0] wait_now;
  logic [N_M-1:0] seen_wait;
  logic [N_M-1:0] cand;
  logic [MW-1:0]  grant_id;
  logic [N_M-1:0] req_sent_n, ack_n, data_read_n;
  logic           s_req_n, s_cmd_n;
  logic [MW-1:0]  s_mid_n;
  logic           push, pop;
  logic [MW-1:0]  head;
  logic           empty;

  // A request is only eligible from its second WAIT cycle on, because the
  // tracker is still settling its slave field during the first one. Reads
  // are held back while the response queue cannot take another ID.
  always_comb begin
    wait_now = '0;
    cand     = '0;
    for (int i = 0; i < N_M; i++) begin
      wait_now[i] = (m_stat[2*i +: 2] == WAIT);
      cand[i]     = wait_now[i] && seen_wait[i] && (m_slave[i] == SLAVE_ID[0])
                    && !((m_cmd[i] == CMD_READ) && rq_full);
    end
  end

`ifdef S_ARB_RR_EN
  logic [MW-1:0] rr_ptr, rr_n;

  // Scan from the farthest offset down so the nearest candidate after
  // rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx      = 0;
    grant_id = '0;
    for (int k = N_M-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_M) idx = idx - N_M;
      if (cand[idx]) grant_id = MW'(idx);
    end
  end

  always_comb begin
    rr_n = rr_ptr;
    if (state == REQ && s_ack)
      rr_n = (s_mid == MW'(N_M-1)) ? '0 : s_mid + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_n;
  end
`else
  always_comb begin
    grant_id = '0;
    for (int i = N_M-1; i >= 0; i--) begin
      if (cand[i]) grant_id = MW'(i);
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    req_sent_n  = '0;
    ack_n       = '0;
    data_read_n = '0;
    s_req_n     = s_req;
    s_cmd_n     = s_cmd;
    s_mid_n     = s_mid;
    push        = 1'b0;
    pop         = s_rvalid && !empty;

    case (state)
      IDLE: begin
        if (|cand) begin
          s_mid_n              = grant_id;
          s_cmd_n              = m_cmd[grant_id];
          req_sent_n[grant_id] = 1'b1;
          s_req_n              = 1'b1;
          state_n              = REQ;
        end
      end
      REQ: begin
        if (s_ack) begin
          s_req_n       = 1'b0;
          ack_n[s_mid]  = 1'b1;
          push          = (s_cmd == CMD_READ);
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) data_read_n[head] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      seen_wait <= '0;
      req_sent  <= '0;
      ack_out   <= '0;
      data_read <= '0;
      s_req     <= 1'b0;
      s_cmd     <= 1'b0;
      s_mid     <= '0;
    end else begin
      state     <= state_n;
      seen_wait <= wait_now;
      req_sent  <= req_sent_n;
      ack_out   <= ack_n;
      data_read <= data_read_n;
      s_req     <= s_req_n;
      s_cmd     <= s_cmd_n;
      s_mid     <= s_mid_n;
    end
  end

  s_arbiter_rq_fifo #(
    .DEPTH (RQ_DEPTH),
    .W     (MW)
  ) u_rq_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (s_mid),
    .pop     (pop),
    .head    (head),
    .full    (rq_full),
    .empty   (empty)
  );

endmodule
`default_nettype wire

// File: doc/s_arbiter.md
Name: s_arbiter

Overview:
- Per-slave arbitration stage. Sits directly downstream of the per-master request trackers (one tracker per master) and upstream of one slave port.
- Selects one master among those in WAIT whose target slave matches SLAVE_ID.
- Forwards the request to the slave and returns req_sent, ack and data_read strobes to the trackers.
- Keeps master IDs of accepted reads in an in-order response queue so read data is routed to the right master.

Parameters:
- N_M, 2, number of masters (2..8)
- SLAVE_ID, 0, slave index served by this instance (0 or 1; compared with the 1-bit tracker slave field)
- RQ_DEPTH, 4, depth of the read-response ID queue (power of two, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  async reset, active-low
- m_stat  in  2*N_M  tracker states, master i at [2i+1:2i]: 0 NO_REQ, 1 WAIT, 2 W_ACK, 3 W_DATA
- m_slave  in  N_M  per-master target slave bit
- m_cmd  in  N_M  per-master command, 1 write, 0 read; sampled at grant
- req_sent  out  N_M  one-hot one-cycle pulse to the granted tracker (WAIT -> W_ACK)
- ack_out  out  N_M  one-hot one-cycle pulse when the slave acks the granted master
- data_read  out  N_M  one-hot one-cycle pulse when read data for that master returns (W_DATA -> NO_REQ)
- s_req  out  1  request to slave
- s_cmd  out  1  latched command of the current grant
- s_mid  out  clog2(N_M)  granted master ID
- s_ack  in  1  slave accepts request
- s_rvalid  in  1  slave read data valid, one beat per read, in order
- rq_full  out  1  response queue full

Behaviour:
- Reset, asynchronous and active-low: all outputs 0; FSM in IDLE; rr_ptr = 0; queue empty; seen_wait = 0.
- Qualification:
  - seen_wait[i] is registered as (m_stat[i] == WAIT).
  - Master i is a candidate when m_stat[i] == WAIT, seen_wait[i] == 1 and m_slave[i] == SLAVE_ID.
  - The trackers update the slave field during the first WAIT cycle, so requests are never granted in their first WAIT cycle.
- Read blocking: a candidate with m_cmd == 0 is masked while rq_full == 1. Write candidates are unaffected.
- FSM IDLE:
  - If any candidate exists, pick g by round-robin starting at rr_ptr. Latch s_mid = g and s_cmd = m_cmd[g].
  - Registered req_sent[g] = 1 for exactly one cycle; go to REQ.
  - Grant latency: 1 cycle from the qualified candidate to the req_sent pulse and s_req rising together.
- FSM REQ:
  - s_req = 1 and is held until s_ack.
  - On s_ack: s_req drops next cycle; ack_out[s_mid] pulses one cycle (registered); rr_ptr = s_mid + 1 mod N_M.
  - If s_cmd == 0, push s_mid into the queue. Return to IDLE.
  - Minimum spacing between grants is 2 cycles (IDLE must be re-entered).
- Response queue:
  - On s_rvalid with the queue non-empty: pop the head; data_read[head] pulses one cycle (registered).
  - Push and pop in the same cycle are both performed; count unchanged.
  - s_rvalid with the queue empty is ignored and nothing pulses.
  - Pointers wrap modulo RQ_DEPTH.
  - rq_full = (count == RQ_DEPTH). The read mask guarantees no push occurs when full.
- Simultaneous s_ack and s_rvalid: both are processed. ack_out and data_read may pulse in the same cycle, to the same or different masters.
- Reset mid-operation: the FSM aborts, the queue is flushed and all strobes are cleared immediately (asynchronous).

Optional Feature:
- Macro S_ARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest index wins; rr_ptr logic is removed and has no side effects.

Decomposition:
- Shared package: tracker state constants NO_REQ/WAIT/W_ACK/W_DATA (shared with the per-master tracker), arbiter state encoding IDLE/REQ, CMD_READ/CMD_WRITE constants.
- Sub-module: rq_fifo, a parameterised ID FIFO with push, pop, head, full and empty.

Test Plan:
- N_M=2, SLAVE_ID=0, master0 WAIT for two cycles, slave bit 0, write → req_sent[0] pulse, s_req=1, s_cmd=1. Slave acks 3 cycles later → ack_out[0] pulse, no queue push, data_read stays 0.
- Both masters WAIT on slave 0 continuously with writes, RR enabled → grants alternate 0,1,0,1. With S_ARB_RR_EN undefined → master0 is always granted.
- Reads from m0 then m1, both acked, then two s_rvalid beats → data_read[0] then data_read[1], in order.
- RQ_DEPTH=2: two reads acked without s_rvalid → rq_full=1. A third read candidate is not granted while a write candidate is granted. One s_rvalid → rq_full=0 and the read is granted.
- s_ack for a read in the same cycle as s_rvalid for an older read → push and pop both occur, count unchanged, data_read pulses for the older ID.
- Master WAIT with m_slave=1 on a SLAVE_ID=0 instance → never granted. s_rvalid with an empty queue → no pulses. Reset asserted while in REQ → s_req=0 immediately, queue empty.
